// File: rtl/cc_regaddr_select.sv
// -----------------------------------------------------------------------------
// cc_regaddr_select
//
// Register-address selector for the microprogrammed datapath. It sits between
// the IR/scratchpad field decoder, the MIR and the register file.
//
// For every address channel it picks either a zero-extended IR field (taken
// from an internal IR latch) or a MIR field, and registers the result
// (stage 1). Channels 0..NUM_CHANNELS-2 are read ports. Channel
// NUM_CHANNELS-1 is the write port.
//
// The write-port address and its write enable are carried through a
// WB_DELAY-deep write-back delay line. Reads that hit an in-flight valid,
// non-zero write address raise Conflict_Out.
//
// Ports
//   CC_REGADDR_SELECT_CLOCK_50                  system clock, rising edge
//   CC_REGADDR_SELECT_RESET_InHigh              asynchronous active-high reset
//   CC_REGADDR_SELECT_IRLoad_In                 load the IR latch from the scratchpad bus
//   CC_REGADDR_SELECT_ScratchpadSelection_InBus IR fields, channel 0 at LSBs
//   CC_REGADDR_SELECT_MIRSelection_InBus        MIR fields, channel 0 at LSBs
//   CC_REGADDR_SELECT_Select_InBus              per channel: 1 = MIR, 0 = IR latch
//   CC_REGADDR_SELECT_WriteEnable_In            write request for the write channel
//   CC_REGADDR_SELECT_Advance_In                pipeline enable (0 = stall)
//   CC_REGADDR_SELECT_data_OutBus               stage-1 addresses, channel 0 at LSBs
//   CC_REGADDR_SELECT_WriteAddr_OutBus          write address at end of the delay line
//   CC_REGADDR_SELECT_WriteValid_Out            write enable at end of the delay line
//   CC_REGADDR_SELECT_Conflict_Out              read-after-write hazard flag
// -----------------------------------------------------------------------------
module cc_regaddr_select #(
    parameter int DATAWIDTH_SCRATCHPAD_DIRECTION = 5,
    parameter int DATAWIDTH_MIR_DIRECTION        = 6,
    parameter int NUM_CHANNELS                   = 3,
    parameter int WB_DELAY                       = 2
) (
    input  logic                                                CC_REGADDR_SELECT_CLOCK_50,
    input  logic                                                CC_REGADDR_SELECT_RESET_InHigh,
    input  logic                                                CC_REGADDR_SELECT_IRLoad_In,
    input  logic [NUM_CHANNELS*DATAWIDTH_SCRATCHPAD_DIRECTION-1:0] CC_REGADDR_SELECT_ScratchpadSelection_InBus,
    input  logic [NUM_CHANNELS*DATAWIDTH_MIR_DIRECTION-1:0]     CC_REGADDR_SELECT_MIRSelection_InBus,
    input  logic [NUM_CHANNELS-1:0]                             CC_REGADDR_SELECT_Select_InBus,
    input  logic                                                CC_REGADDR_SELECT_WriteEnable_In,
    input  logic                                                CC_REGADDR_SELECT_Advance_In,
    output logic [NUM_CHANNELS*DATAWIDTH_MIR_DIRECTION-1:0]     CC_REGADDR_SELECT_data_OutBus,
    output logic [DATAWIDTH_MIR_DIRECTION-1:0]                  CC_REGADDR_SELECT_WriteAddr_OutBus,
    output logic                                                CC_REGADDR_SELECT_WriteValid_Out,
    output logic                                                CC_REGADDR_SELECT_Conflict_Out
);

    localparam int SpW   = DATAWIDTH_SCRATCHPAD_DIRECTION;
    localparam int MirW  = DATAWIDTH_MIR_DIRECTION;
    localparam int NumCh = NUM_CHANNELS;
    localparam int WrCh  = NUM_CHANNELS - 1;

    // Elaboration-time parameter sanity.
    if (SpW > MirW) begin : gBadFieldWidth
        $error("cc_regaddr_select: scratchpad field wider than MIR field");
    end
    if (NumCh < 2) begin : gBadChannelCount
        $error("cc_regaddr_select: at least one read and one write channel required");
    end
    if (WB_DELAY < 0 || WB_DELAY > 4) begin : gBadDelay
        $error("cc_regaddr_select: WB_DELAY must be in 0..4");
    end

    logic clk;
    logic rst;
    logic adv;

    assign clk = CC_REGADDR_SELECT_CLOCK_50;
    assign rst = CC_REGADDR_SELECT_RESET_InHigh;
    assign adv = CC_REGADDR_SELECT_Advance_In;

    // IR fields are narrower than register addresses; the upper bits are zero.
    function automatic logic [MirW-1:0] zeroExtend(input logic [SpW-1:0] field);
        logic [MirW-1:0] ext;
        ext            = '0;
        ext[SpW-1:0]   = field;
        return ext;
    endfunction

    // ---- stage 0: IR latch and per-channel source mux -----------------------
    // The latch ignores Advance_In so the decoder can refill it during stalls.
    logic [NumCh*SpW-1:0]  irLatch_p0;
    logic [NumCh*MirW-1:0] selAddr_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irLatch_p0 <= '0;
        end else if (CC_REGADDR_SELECT_IRLoad_In) begin
            irLatch_p0 <= CC_REGADDR_SELECT_ScratchpadSelection_InBus;
        end
    end

    // The mux reads the latch register, never the scratchpad bus, so a field
    // loaded on an edge is not visible to stage 1 until the following edge.
    always_comb begin
        selAddr_p0 = '0;
        for (int ch = 0; ch < NumCh; ch++) begin
            if (CC_REGADDR_SELECT_Select_InBus[ch]) begin
                selAddr_p0[ch*MirW +: MirW] = CC_REGADDR_SELECT_MIRSelection_InBus[ch*MirW +: MirW];
            end else begin
                selAddr_p0[ch*MirW +: MirW] = zeroExtend(irLatch_p0[ch*SpW +: SpW]);
            end
        end
    end

    // ---- stage 1: registered channel addresses and write enable -------------
    logic [NumCh*MirW-1:0] addr_p1;
    logic                  vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (adv) begin
            addr_p1 <= selAddr_p0;
            vld_p1  <= CC_REGADDR_SELECT_WriteEnable_In;
        end
    end

    assign CC_REGADDR_SELECT_data_OutBus = addr_p1;

    // ---- stage 2..: write-back delay line -----------------------------------
    if (WB_DELAY > 0) begin : gDelay
        logic [MirW-1:0]     wbAddr_p2 [WB_DELAY];
        logic [WB_DELAY-1:0] wbVld_p2;
        logic                conflict;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < WB_DELAY; i++) begin
                    wbAddr_p2[i] <= '0;
                end
                wbVld_p2 <= '0;
            end else if (adv) begin
                wbAddr_p2[0] <= addr_p1[WrCh*MirW +: MirW];
                wbVld_p2[0]  <= vld_p1;
                for (int i = 1; i < WB_DELAY; i++) begin
                    wbAddr_p2[i] <= wbAddr_p2[i-1];
                    wbVld_p2[i]  <= wbVld_p2[i-1];
                end
            end
        end

        // Hazard compare uses only registered values, so it cannot glitch on
        // input changes. Address 0 is the hardwired zero register and never
        // creates a real dependency.
        always_comb begin
            conflict = 1'b0;
            for (int r = 0; r < NumCh - 1; r++) begin
                for (int e = 0; e < WB_DELAY; e++) begin
                    if (wbVld_p2[e]
                        && (addr_p1[r*MirW +: MirW] != '0)
                        && (addr_p1[r*MirW +: MirW] == wbAddr_p2[e])) begin
                        conflict = 1'b1;
                    end
                end
            end
        end

        assign CC_REGADDR_SELECT_WriteAddr_OutBus = wbAddr_p2[WB_DELAY-1];
        assign CC_REGADDR_SELECT_WriteValid_Out   = wbVld_p2[WB_DELAY-1];
        assign CC_REGADDR_SELECT_Conflict_Out     = conflict;
    end else begin : gNoDelay
        // No delay line: the write leaves straight from stage 1 and nothing
        // can be in flight, so there is never a hazard.
        assign CC_REGADDR_SELECT_WriteAddr_OutBus = addr_p1[WrCh*MirW +: MirW];
        assign CC_REGADDR_SELECT_WriteValid_Out   = vld_p1;
        assign CC_REGADDR_SELECT_Conflict_Out     = 1'b0;
    end

endmodule

// File: tb/tb_cc_regaddr_select.sv
// -----------------------------------------------------------------------------
// tb_cc_regaddr_select
//
// Directed bench for cc_regaddr_select. Instance dutA uses the default
// parameters (SP=5, MIR=6, 3 channels, WB_DELAY=2). Instance dutB uses
// 4 channels with WB_DELAY=0 and is driven with random vectors against a
// small reference model.
// -----------------------------------------------------------------------------
module tb_cc_regaddr_select;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    // ---- instance A signals ----
    logic        rst;
    logic        irLoad;
    logic [14:0] sp;
    logic [17:0] mir;
    logic [2:0]  sel;
    logic        we;
    logic        adv;
    logic [17:0] data;
    logic [5:0]  waddr;
    logic        wvalid;
    logic        conflict;

    // ---- instance B signals ----
    logic        rstB;
    logic        bIrLoad;
    logic [19:0] bSp;
    logic [23:0] bMir;
    logic [3:0]  bSel;
    logic        bWe;
    logic        bAdv;
    logic [23:0] bData;
    logic [5:0]  bWaddr;
    logic        bWvalid;
    logic        bConflict;

    cc_regaddr_select dutA (
        .CC_REGADDR_SELECT_CLOCK_50                  (clk),
        .CC_REGADDR_SELECT_RESET_InHigh              (rst),
        .CC_REGADDR_SELECT_IRLoad_In                 (irLoad),
        .CC_REGADDR_SELECT_ScratchpadSelection_InBus (sp),
        .CC_REGADDR_SELECT_MIRSelection_InBus        (mir),
        .CC_REGADDR_SELECT_Select_InBus              (sel),
        .CC_REGADDR_SELECT_WriteEnable_In            (we),
        .CC_REGADDR_SELECT_Advance_In                (adv),
        .CC_REGADDR_SELECT_data_OutBus               (data),
        .CC_REGADDR_SELECT_WriteAddr_OutBus          (waddr),
        .CC_REGADDR_SELECT_WriteValid_Out            (wvalid),
        .CC_REGADDR_SELECT_Conflict_Out              (conflict)
    );

    cc_regaddr_select #(
        .DATAWIDTH_SCRATCHPAD_DIRECTION (5),
        .DATAWIDTH_MIR_DIRECTION        (6),
        .NUM_CHANNELS                   (4),
        .WB_DELAY                       (0)
    ) dutB (
        .CC_REGADDR_SELECT_CLOCK_50                  (clk),
        .CC_REGADDR_SELECT_RESET_InHigh              (rstB),
        .CC_REGADDR_SELECT_IRLoad_In                 (bIrLoad),
        .CC_REGADDR_SELECT_ScratchpadSelection_InBus (bSp),
        .CC_REGADDR_SELECT_MIRSelection_InBus        (bMir),
        .CC_REGADDR_SELECT_Select_InBus              (bSel),
        .CC_REGADDR_SELECT_WriteEnable_In            (bWe),
        .CC_REGADDR_SELECT_Advance_In                (bAdv),
        .CC_REGADDR_SELECT_data_OutBus               (bData),
        .CC_REGADDR_SELECT_WriteAddr_OutBus          (bWaddr),
        .CC_REGADDR_SELECT_WriteValid_Out            (bWvalid),
        .CC_REGADDR_SELECT_Conflict_Out              (bConflict)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, "_data"},     32'(data),     32'h0);
        checkEq({tag, "_waddr"},    32'(waddr),    32'h0);
        checkEq({tag, "_wvalid"},   32'(wvalid),   32'h0);
        checkEq({tag, "_conflict"}, 32'(conflict), 32'h0);
    endtask

    // Reference model for instance B.
    logic [19:0] mLatch;
    logic [23:0] mData;
    logic        mWe;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irLoad = 1'b0; sp = '0; mir = '0; sel = '0; we = 1'b0; adv = 1'b0;
        rstB = 1'b1; bIrLoad = 1'b0; bSp = '0; bMir = '0; bSel = '0; bWe = 1'b0; bAdv = 1'b0;
        mLatch = '0; mData = '0; mWe = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        rst  = 1'b0;
        rstB = 1'b0;
        checkAllZero("rst_init");

        // ---- fill the pipeline with all ones, then reset mid-cycle ----
        irLoad = 1'b1; sp = '1; mir = '1; sel = '1; we = 1'b1; adv = 1'b1;
        tick();
        tick();
        tick();
        checkEq("ones_data",     32'(data),     32'h3FFFF);
        checkEq("ones_waddr",    32'(waddr),    32'h3F);
        checkEq("ones_wvalid",   32'(wvalid),   32'h1);
        checkEq("ones_conflict", 32'(conflict), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("rst_async");
        tick();
        rst = 1'b0;
        adv = 1'b0;
        tick();
        checkAllZero("rst_stall");
        adv = 1'b1;
        tick();
        checkEq("rst_first_adv_data",   32'(data),   32'h3FFFF);
        checkEq("rst_first_adv_wvalid", 32'(wvalid), 32'h0);

        // ---- mux and zero extension ----
        irLoad = 1'b1; sp = 15'h001F; adv = 1'b0; we = 1'b0;
        tick();
        irLoad = 1'b0; sel = 3'b000; mir = 18'h0002A; adv = 1'b1;
        tick();
        checkEq("mux_ir_zext", 32'(data), 32'h0001F);
        sel = 3'b001;
        tick();
        checkEq("mux_mir", 32'(data), 32'h0002A);

        // ---- IR latch is not bypassed ----
        irLoad = 1'b1; sp = 15'h0003; adv = 1'b0; sel = 3'b000;
        tick();
        irLoad = 1'b1; sp = 15'h0009; adv = 1'b1;
        tick();
        checkEq("nobypass_old", 32'(data), 32'h00003);
        irLoad = 1'b0;
        tick();
        checkEq("nobypass_new", 32'(data), 32'h00009);

        // ---- write delay line ----
        we = 1'b0; sel = 3'b000; mir = '0;
        tick();
        tick();
        sel = 3'b100; mir = 18'h05000; we = 1'b1;
        tick();
        checkEq("wb_e1_wvalid", 32'(wvalid), 32'h0);
        we = 1'b0; mir = '0;
        tick();
        checkEq("wb_e2_wvalid", 32'(wvalid), 32'h0);
        tick();
        checkEq("wb_e3_waddr",  32'(waddr),  32'h05);
        checkEq("wb_e3_wvalid", 32'(wvalid), 32'h1);
        tick();
        checkEq("wb_e4_wvalid", 32'(wvalid), 32'h0);

        // Same write with a four-cycle stall in flight.
        mir = 18'h05000; we = 1'b1;
        tick();
        we = 1'b0; mir = '0;
        tick();
        adv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkEq("stall_wvalid", 32'(wvalid), 32'h0);
        end
        adv = 1'b1;
        tick();
        checkEq("stall_arrive_waddr",  32'(waddr),  32'h05);
        checkEq("stall_arrive_wvalid", 32'(wvalid), 32'h1);

        // ---- read-after-write conflict ----
        we = 1'b0; mir = '0; sel = 3'b000;
        tick();
        tick();
        tick();
        sel = 3'b110; mir = 18'h071C0; we = 1'b1;
        tick();
        we = 1'b0; mir = 18'h001C0;
        tick();
        checkEq("raw_hit", 32'(conflict), 32'h1);
        tick();
        tick();
        checkEq("raw_drained", 32'(conflict), 32'h0);

        // Write to address 0 never conflicts but is still delivered.
        mir = 18'h00000; we = 1'b1;
        tick();
        we = 1'b0;
        tick();
        checkEq("raw_addr0", 32'(conflict), 32'h0);
        tick();
        checkEq("raw_addr0_wvalid", 32'(wvalid), 32'h1);
        checkEq("raw_addr0_waddr",  32'(waddr),  32'h00);

        // Matching address without a write enable never conflicts.
        tick();
        tick();
        mir = 18'h071C0; we = 1'b0;
        tick();
        mir = 18'h001C0;
        tick();
        checkEq("raw_no_we", 32'(conflict), 32'h0);

        // ---- WB_DELAY=0, 4 channels, random stimulus ----
        for (int i = 0; i < 24; i++) begin
            logic [23:0] nextData;
            bSp     = 20'($urandom);
            bMir    = 24'($urandom);
            bSel    = 4'($urandom_range(0, 15));
            bWe     = 1'($urandom_range(0, 1));
            bAdv    = ($urandom_range(0, 3) != 0);
            bIrLoad = 1'($urandom_range(0, 1));
            tick();
            nextData = mData;
            if (bAdv) begin
                for (int ch = 0; ch < 4; ch++) begin
                    if (bSel[ch]) begin
                        nextData[ch*6 +: 6] = bMir[ch*6 +: 6];
                    end else begin
                        nextData[ch*6 +: 6] = {1'b0, mLatch[ch*5 +: 5]};
                    end
                end
                mWe = bWe;
            end
            mData = nextData;
            if (bIrLoad) begin
                mLatch = bSp;
            end
            checkEq("nodly_data",     32'(bData),     32'(mData));
            checkEq("nodly_waddr",    32'(bWaddr),    32'(mData[23:18]));
            checkEq("nodly_wvalid",   32'(bWvalid),   32'(mWe));
            checkEq("nodly_conflict", 32'(bConflict), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
